// File: rtl/pe_output_packer_pkg.sv
// Shared types and helpers for the PE output packer: precision encoding,
// FSM states and per-precision lane geometry.
package pe_output_packer_pkg;

  localparam int ACC_DATA_WIDTH = 32;
  localparam int ACT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    PREC_8     = 2'd0,
    PREC_4     = 2'd1,
    PREC_2     = 2'd2,
    PREC_8_ALT = 2'd3
  } prec_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic [3:0] elem_width(prec_e p);
    case (p)
      PREC_4:  return 4'd4;
      PREC_2:  return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

  // Index of the last lane in a 32-bit word for this precision.
  function automatic logic [3:0] last_lane(prec_e p);
    case (p)
      PREC_4:  return 4'd7;
      PREC_2:  return 4'd15;
      default: return 4'd3;
    endcase
  endfunction

endpackage

// File: rtl/pe_packer_fifo.sv
// Output word FIFO for the packer: holds data, address and last flag per entry.
// Head entry is read straight from the storage flops, so it is stable until popped.
module pe_packer_fifo
  import pe_output_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [ACC_DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0]     push_addr,
  input  logic                      push_last,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [ACC_DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [ACC_DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]     addr_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     last_q;
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]            cnt_q;
  logic                      do_push, do_pop;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rd_data = data_q[rd_ptr_q];
  assign rd_addr = addr_q[rd_ptr_q];
  assign rd_last = last_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= push_data;
        addr_q[wr_ptr_q] <= push_addr;
        last_q[wr_ptr_q] <= push_last;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pe_output_packer.sv
// Packs a stream of signed PE outputs into 32-bit memory words at 8/4/2-bit
// precision. Define PE_PACKER_SATURATE_EN to clamp inputs instead of truncating.
module pe_output_packer
  import pe_output_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            precision,
  input  logic [15:0]           num_elements,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_e                  state_q, state_d;
  prec_e                   prec_q, prec_d;
  logic [15:0]             num_q, num_d, cnt_q, cnt_d;
  logic [3:0]              lane_q, lane_d;
  logic [31:0]             word_q, word_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;

  logic                    fifo_full, fifo_empty;
  logic                    accept, last_elem, push;
  logic [3:0]              w;
  logic [4:0]              sh;
  logic [31:0]             elem_v, push_word;

  assign w         = elem_width(prec_q);
  assign sh        = 5'(lane_q) * 5'(w);
  assign in_ready  = (state_q == S_PACK) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign last_elem = (cnt_q == num_q - 16'd1);
  assign push      = accept && (lane_q == last_lane(prec_q) || last_elem);
  assign push_word = word_q | ((elem_v & ((32'd1 << w) - 32'd1)) << sh);
  assign out_valid = !fifo_empty;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

`ifdef PE_PACKER_SATURATE_EN
  logic signed [31:0] in_s, smax, smin;
  assign in_s = in_data;
  always_comb begin
    smax = 32'sd127;
    smin = -32'sd128;
    case (prec_q)
      PREC_4:  begin smax = 32'sd7; smin = -32'sd8; end
      PREC_2:  begin smax = 32'sd1; smin = -32'sd2; end
      default: ;
    endcase
    if (in_s > smax)      elem_v = smax;
    else if (in_s < smin) elem_v = smin;
    else                  elem_v = in_s;
  end
`else
  assign elem_v = in_data;
`endif

  always_comb begin
    state_d = state_q;
    prec_d  = prec_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        prec_d  = prec_e'(precision);
        num_d   = num_elements;
        waddr_d = base_addr;
        cnt_d   = '0;
        lane_d  = '0;
        word_d  = '0;
        state_d = (num_elements == 16'd0) ? S_DONE : S_PACK;
      end
      S_PACK: if (accept) begin
        cnt_d = cnt_q + 16'd1;
        if (push) begin
          lane_d  = '0;
          word_d  = '0;
          waddr_d = waddr_q + ADDR_WIDTH'(4);
        end else begin
          lane_d = lane_q + 4'd1;
          word_d = push_word;
        end
        if (last_elem) state_d = S_DRAIN;
      end
      // Only the final word carries last, so its handshake ends the transfer.
      S_DRAIN: if (out_valid && out_ready && out_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      prec_q  <= PREC_8;
      num_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      prec_q  <= prec_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
    end
  end

  pe_packer_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_word),
    .push_addr(waddr_q),
    .push_last(last_elem),
    .pop      (out_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .rd_data  (out_data),
    .rd_addr  (out_addr),
    .rd_last  (out_last)
  );

endmodule

// File: tb/tb_pe_output_packer.sv
// Directed bench for pe_output_packer: packing at each precision, backpressure,
// address wrap, start-while-busy and mid-transfer reset.
module tb_pe_output_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  precision;
  logic [15:0] num_elements;
  logic [15:0] base_addr;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [15:0] out_addr;
  logic        out_last, busy, done;

  pe_output_packer #(.FIFO_DEPTH(4), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .precision(precision),
    .num_elements(num_elements), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, sent = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, hs_cyc = 0;
  logic [31:0] q_data[$];
  logic [15:0] q_addr[$];
  logic        q_last[$];

  // Handshakes observed mid-cycle happen at the following rising edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_addr.push_back(out_addr);
      q_last.push_back(out_last);
      hs_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic start_xfer(input logic [1:0] p, input logic [15:0] n, input logic [15:0] b);
    @(posedge clk); #1;
    precision = p; num_elements = n; base_addr = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    int n = 0;
    logic ok;
    in_data = v; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    ok = in_ready;
    if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ok) sent++;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 500) begin @(negedge clk); n++; end
    if (done_cnt == prev) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_q();
    q_data.delete(); q_addr.delete(); q_last.delete();
  endtask

  int d0;
  logic [31:0] exp_w;

  initial begin
    reset = 1'b0; start = 1'b0; precision = 2'd0; num_elements = '0; base_addr = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    @(negedge clk); reset = 1'b1;

    // 8-bit, single full word
    clear_q(); d0 = done_cnt;
    start_xfer(2'd0, 16'd4, 16'h0100);
    chk("t1_busy", 32'(busy), 32'd1);
    send(32'd1); send(32'd2); send(-32'sd1); send(32'd127);
    chk("t1_valid_next_cycle", 32'(out_valid), 32'd1);
    wait_done(d0);
    repeat (3) @(negedge clk);
    chk("t1_nwords", 32'(q_data.size()), 32'd1);
    if (q_data.size() == 1) begin
      chk("t1_data", q_data[0], 32'h7FFF0201);
      chk("t1_addr", 32'(q_addr[0]), 32'h100);
      chk("t1_last", 32'(q_last[0]), 32'd1);
    end
    chk("t1_done_after_hs", 32'(done_cyc - hs_cyc), 32'd1);
    chk("t1_done_one_pulse", 32'(done_cnt - d0), 32'd1);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // 4-bit, partial final word; start mid-transfer must be ignored
    clear_q(); d0 = done_cnt;
    start_xfer(2'd1, 16'd10, 16'h0200);
    for (int i = 0; i < 3; i++) send(32'(i));
    start_xfer(2'd0, 16'd1, 16'h0000);
    for (int i = 3; i < 10; i++) send(32'(i));
    wait_done(d0);
    repeat (2) @(negedge clk);
    chk("t2_nwords", 32'(q_data.size()), 32'd2);
    if (q_data.size() == 2) begin
      chk("t2_data0", q_data[0], 32'h76543210);
      chk("t2_addr0", 32'(q_addr[0]), 32'h200);
      chk("t2_last0", 32'(q_last[0]), 32'd0);
      chk("t2_data1", q_data[1], 32'h00000098);
      chk("t2_addr1", 32'(q_addr[1]), 32'h204);
      chk("t2_last1", 32'(q_last[1]), 32'd1);
    end

    // 2-bit out-of-range values
    clear_q(); d0 = done_cnt;
    start_xfer(2'd2, 16'd2, 16'h0300);
    send(32'd300); send(-32'sd5);
    wait_done(d0);
    repeat (2) @(negedge clk);
`ifdef PE_PACKER_SATURATE_EN
    exp_w = 32'h00000009;
`else
    exp_w = 32'h0000000C;
`endif
    chk("t3_nwords", 32'(q_data.size()), 32'd1);
    if (q_data.size() == 1) chk("t3_data", q_data[0], exp_w);

    // precision code 3 behaves as 8-bit
    clear_q(); d0 = done_cnt;
    start_xfer(2'd3, 16'd1, 16'h0400);
    send(-32'sd1);
    wait_done(d0);
    repeat (2) @(negedge clk);
    chk("t4_nwords", 32'(q_data.size()), 32'd1);
    if (q_data.size() == 1) chk("t4_data", q_data[0], 32'h000000FF);

    // backpressure with address wrap
    clear_q(); d0 = done_cnt; sent = 0;
    out_ready = 1'b0;
    start_xfer(2'd0, 16'd24, 16'hFFF8);
    fork
      for (int i = 0; i < 24; i++) send(32'(i));
      begin
        repeat (24) @(negedge clk);
        chk("t5_in_ready_low", 32'(in_ready), 32'd0);
        chk("t5_sent_at_stall", 32'(sent), 32'd16);
        chk("t5_head_valid", 32'(out_valid), 32'd1);
        chk("t5_head_data", out_data, 32'h03020100);
        chk("t5_head_addr", 32'(out_addr), 32'hFFF8);
        repeat (5) @(negedge clk);
        chk("t5_head_data_held", out_data, 32'h03020100);
        chk("t5_head_addr_held", 32'(out_addr), 32'hFFF8);
        out_ready = 1'b1;
      end
    join
    wait_done(d0);
    repeat (2) @(negedge clk);
    chk("t5_nwords", 32'(q_data.size()), 32'd6);
    if (q_data.size() == 6) begin
      for (int j = 0; j < 6; j++) begin
        exp_w = '0;
        for (int k = 0; k < 4; k++) exp_w |= 32'(4*j + k) << (8*k);
        chk($sformatf("t5_data%0d", j), q_data[j], exp_w);
        chk($sformatf("t5_addr%0d", j), 32'(q_addr[j]), 32'(16'(16'hFFF8 + 16'(4*j))));
        chk($sformatf("t5_last%0d", j), 32'(q_last[j]), 32'(j == 5));
      end
    end

    // reset mid-transfer, then an empty transfer
    clear_q();
    start_xfer(2'd0, 16'd8, 16'h0500);
    send(32'd11); send(32'd22); send(32'd33);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_out_data", out_data, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_words", 32'(q_data.size()), 32'd0);
    d0 = done_cnt;
    start_xfer(2'd0, 16'd0, 16'h0600);
    wait_done(d0);
    repeat (3) @(negedge clk);
    chk("t6_done_one_pulse", 32'(done_cnt - d0), 32'd1);
    chk("t6_still_no_words", 32'(q_data.size()), 32'd0);
    chk("t6_busy_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
